// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes N_REQ byte streams onto a single UART transmitter.
// Build option: define UART_TX_ARB_PKT_LOCK_EN to hold a grant until req_last or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic          any_valid;
  logic          grant_valid;
  logic [7:0]    grant_byte;
  logic          out_ready;
  logic          req_hs;
  logic          tx_hs;
  logic          grant_done;
  int unsigned   scan_idx;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  localparam logic [15:0] TIMEOUT = 16'(IDLE_TIMEOUT);
  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_inc;
  logic        grant_last;

  // saturating count of grant cycles without a requester handshake
  assign idle_cnt_inc = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
  assign grant_done   = req_hs ? grant_last : (idle_cnt_inc >= TIMEOUT);
`else
  // packet boundaries and the idle timeout have no function when every grant is one byte
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{req_last, 16'(IDLE_TIMEOUT)};
  assign grant_done      = req_hs;
`endif

  assign out_ready = !tx_valid || tx_ready;
  assign req_hs    = (state == GRANT) && grant_valid && out_ready;
  assign tx_hs     = tx_valid && tx_ready;
  assign busy      = (state != IDLE) || tx_valid;

  // round-robin search beginning one past the previous grantee
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_ptr) + 32'd1 + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!any_valid && req_valid[GW'(scan_idx)]) begin
        any_valid = 1'b1;
        winner    = GW'(scan_idx);
      end
    end
  end

  // select the grantee's lane and steer ready back to it only
  always_comb begin
    grant_valid = 1'b0;
    grant_byte  = '0;
    req_ready   = '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
    grant_last  = 1'b0;
`endif
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (GW'(k) == grant_id) begin
        grant_valid  = req_valid[k];
        grant_byte   = req_data[8*k +: 8];
`ifdef UART_TX_ARB_PKT_LOCK_EN
        grant_last   = req_last[k];
`endif
        req_ready[k] = (state == GRANT) && out_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(N_REQ - 1);
      tx_valid <= 1'b0;
      tx_data  <= '0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      idle_cnt <= '0;
`endif
    end else begin
      // single-entry output register; a reload on a tx handshake keeps full rate
      if (req_hs) begin
        tx_data  <= grant_byte;
        tx_valid <= 1'b1;
      end else if (tx_hs) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            state    <= GRANT;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            idle_cnt <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
          idle_cnt <= req_hs ? 16'd0 : idle_cnt_inc;
`endif
          if (grant_done) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based model of the arbitration rules.
// Packet-lock scenarios compile in when UART_TX_ARB_PKT_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int p_valid  = 100;
  int p_ready  = 100;

  // pending beats per requester: bit 8 = last, bits 7:0 = data
  int rq [N][$];
  int obs_grant[$];
  int obs_tx[$];

  // model: owner = -1 means no grant held; m_q is the output register contents
  int m_owner, m_gid, m_ptr, m_idle, m_hs_req;
  int m_q[$];
  logic [N-1:0] prev_pend;
  logic [7:0]   prev_data [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int k = 0; k < got.size() && k < exp.size(); k++) check(tag, got[k], exp[k]);
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_gid     = 0;
    m_ptr     = N - 1;
    m_idle    = 0;
    m_hs_req  = -1;
    m_q.delete();
    prev_pend = '0;
  endtask

  // compare DUT outputs with the model, then advance the model by one clock
  task automatic eval_cycle();
    bit exp_txv;
    bit ordy;
    bit done;
    logic [N-1:0] exp_rdy;
    exp_txv = (m_q.size() != 0);
    ordy    = !exp_txv || tx_ready;
    exp_rdy = '0;
    if (m_owner >= 0) exp_rdy[m_owner] = ordy;
    check("tx_valid",  32'(tx_valid),  32'(exp_txv));
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("grant_id",  32'(grant_id),  m_gid);
    check("busy",      32'(busy),      32'((m_owner >= 0) || exp_txv));
    if (exp_txv) check("tx_data", 32'(tx_data), m_q[0]);

    for (int i = 0; i < N; i++) begin
      if (prev_pend[i] && req_valid[i]) check("hazard_data_held", 32'(req_data[8*i +: 8]), 32'(prev_data[i]));
      prev_pend[i] = req_valid[i] && !req_ready[i];
      prev_data[i] = req_data[8*i +: 8];
      if (req_valid[i] && req_ready[i]) obs_grant.push_back(i);
    end
    if (tx_valid && tx_ready) obs_tx.push_back(int'(tx_data));

    m_hs_req = -1;
    if (m_owner >= 0 && req_valid[m_owner] && ordy) m_hs_req = m_owner;
    if (exp_txv && tx_ready) void'(m_q.pop_front());
    if (m_hs_req >= 0) m_q.push_back(int'(req_data[8*m_owner +: 8]));

    if (m_owner >= 0) begin
      if (m_hs_req >= 0) m_idle = 0;
      else if (m_idle < 65535) m_idle++;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      done = (m_hs_req >= 0) ? req_last[m_owner] : (m_idle >= TO);
`else
      done = (m_hs_req >= 0);
`endif
      if (done) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c;
          m_gid   = c;
          m_idle  = 0;
        end
      end
    end
  endtask

  // requesters hold valid/data until accepted; new beats appear with probability p_valid
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (m_hs_req == i) begin
        void'(rq[i].pop_front());
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && rq[i].size() != 0 && $urandom_range(99) < p_valid) begin
        req_valid[i]         = 1'b1;
        req_data[8*i +: 8]   = 8'(rq[i][0]);
        req_last[i]          = (rq[i][0] >= 256);
      end
    end
    tx_ready = ($urandom_range(99) < p_ready);
    m_hs_req = -1;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int bound);
    bit quiet;
    for (int c = 0; c < bound; c++) begin
      quiet = (m_q.size() == 0) && (m_owner < 0) && (req_valid == '0);
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) quiet = 1'b0;
      if (quiet) return;
      cycle();
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tx_valid(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (m_q.size() != 0) return;
      cycle();
    end
    check("wait_tx_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid",  32'(tx_valid),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_grant_id",  32'(grant_id),  32'd0);
    check("rst_tx_data",   32'(tx_data),   32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[$];
    int exp_t[$];
    int pushed;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    model_reset();
    #12;
    check("por_tx_valid",  32'(tx_valid),  32'd0);
    check("por_tx_data",   32'(tx_data),   32'd0);
    check("por_req_ready", 32'(req_ready), 32'd0);
    check("por_grant_id",  32'(grant_id),  32'd0);
    check("por_busy",      32'(busy),      32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // requesters 0 and 2 contend: grants alternate and streams interleave
    for (int j = 0; j < 4; j++) begin
      rq[0].push_back(256 + 8'hA0 + j);
      rq[2].push_back(256 + 8'hC0 + j);
    end
    obs_grant.delete(); obs_tx.delete();
    p_valid = 100; p_ready = 100;
    drive();
    drain(200);
    exp_g = '{0, 2, 0, 2, 0, 2, 0, 2};
    exp_t = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2, 8'hA3, 8'hC3};
    check_seq("alt_grants", obs_grant, exp_g);
    check_seq("alt_tx", obs_tx, exp_t);

    // transmitter stalls with a byte held in the output register
    obs_tx.delete();
    p_ready = 0;
    rq[1].push_back(256 + 8'h55);
    rq[1].push_back(256 + 8'h66);
    drive();
    wait_tx_valid(10);
    repeat (5) begin
      check("stall_tx_valid",  32'(tx_valid),  32'd1);
      check("stall_tx_data",   32'(tx_data),   32'h55);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      cycle();
    end
    p_ready = 100;
    drain(100);
    exp_t = '{8'h55, 8'h66};
    check_seq("stall_tx", obs_tx, exp_t);

    // reset mid-packet drops the pending byte and restarts arbitration at 0
    p_ready = 0;
    rq[2].push_back(8'h21);
    rq[2].push_back(8'h22);
    rq[2].push_back(256 + 8'h23);
    rq[0].push_back(256 + 8'h01);
    drive();
    wait_tx_valid(10);
    obs_grant.delete(); obs_tx.delete();
    do_reset();
    p_ready = 100;
    drain(200);
    exp_g = '{0, 2, 2};
    exp_t = '{8'h01, 8'h22, 8'h23};
    check_seq("rst_grants", obs_grant, exp_g);
    check_seq("rst_tx", obs_tx, exp_t);

    // all four requesters continuously valid
    do_reset();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < N; i++) rq[i].push_back(256 + 16 * i + j);
    obs_grant.delete();
    drive();
    drain(300);
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("all4_grants", obs_grant, exp_g);

`ifdef UART_TX_ARB_PKT_LOCK_EN
    // a locked packet completes before the next requester is served
    do_reset();
    rq[1].push_back(8'h41);
    rq[1].push_back(8'h42);
    rq[1].push_back(256 + 8'h43);
    rq[3].push_back(256 + 8'h99);
    obs_grant.delete(); obs_tx.delete();
    drive();
    drain(200);
    exp_g = '{1, 1, 1, 3};
    exp_t = '{8'h41, 8'h42, 8'h43, 8'h99};
    check_seq("lock_grants", obs_grant, exp_g);
    check_seq("lock_tx", obs_tx, exp_t);

    // unterminated packet releases the grant after the idle timeout
    obs_grant.delete();
    rq[2].push_back(8'h77);
    drive();
    for (int c = 0; c < 20 && rq[2].size() != 0; c++) cycle();
    rq[0].push_back(256 + 8'h10);
    drain(200);
    exp_g = '{2, 0};
    check_seq("timeout_grants", obs_grant, exp_g);
`endif

    // randomized traffic and backpressure
    pushed = 0;
    obs_tx.delete();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        p_valid = int'($urandom_range(100, 20));
        p_ready = int'($urandom_range(100, 10));
      end
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() < 4 && $urandom_range(3) == 0) begin
          rq[i].push_back(int'($urandom_range(255)) + 256 * int'($urandom_range(1)));
          pushed++;
        end
      end
      cycle();
    end
    p_valid = 100; p_ready = 100;
    drain(500);
    check("rand_byte_count", obs_tx.size(), pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
